// File: rtl/lsu_mem_port.sv
// Memory-stage load/store port: turns one EX load/store into a word-aligned req/ack bus transfer.
// Optional bus timeout abort is compiled in with `define LSU_TIMEOUT_EN.
module lsu_mem_port #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid,
   input  logic              i_lsu_wren,
   input  logic              i_lsu_rden,
   input  logic [1:0]        i_size,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_st_data,
   output logic              o_stall,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [3:0]        o_mem_be,
   output logic [31:0]       o_mem_wdata,
   input  logic              i_mem_ack,
   input  logic [31:0]       i_mem_rdata,
   output logic [31:0]       o_ld_data,
   output logic [1:0]        o_ld_offset,
   output logic              o_ld_valid,
   output logic              o_misalign,
   output logic              o_bus_err
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t            state_q;
   logic              memReq_q;
   logic              memWe_q;
   logic [ADDR_W-1:0] memAddr_q;
   logic [3:0]        memBe_q;
   logic [31:0]       memWdata_q;
   logic [3:0]        memBe_d;
   logic [31:0]       memWdata_d;
   logic              isLoad_q;
   logic [1:0]        offset_q;
   logic [31:0]       ldData_q;
   logic [1:0]        ldOffset_q;
   logic              ldValid_q;
   logic              misalign_q;
   logic              isOp;
   logic              misaligned;

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] timeoutCnt_q;
   logic             busErr_q;
`endif

   // Only IDLE may accept, and only an op that is unambiguously a load or a store.
   assign isOp = (state_q == IDLE) && i_valid && (i_lsu_wren ^ i_lsu_rden);

   always_comb begin
      misaligned = 1'b0;
      case (i_size)
         2'd1:    misaligned = i_addr[0];
         2'd2:    misaligned = (i_addr[1:0] != 2'b00);
         2'd3:    misaligned = 1'b1;
         default: misaligned = 1'b0;
      endcase
   end

   // Replicating the store data across lanes lets the enables alone select the bytes written.
   always_comb begin
      memBe_d    = 4'b1111;
      memWdata_d = i_st_data;
      case (i_size)
         2'd0: begin
            memBe_d    = 4'b0001 << i_addr[1:0];
            memWdata_d = {4{i_st_data[7:0]}};
         end
         2'd1: begin
            memBe_d    = 4'b0011 << i_addr[1:0];
            memWdata_d = {2{i_st_data[15:0]}};
         end
         default: begin
            memBe_d    = 4'b1111;
            memWdata_d = i_st_data;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= IDLE;
         memReq_q   <= 1'b0;
         memWe_q    <= 1'b0;
         memAddr_q  <= '0;
         memBe_q    <= 4'b0000;
         memWdata_q <= 32'h0;
         isLoad_q   <= 1'b0;
         offset_q   <= 2'b00;
         ldData_q   <= 32'h0;
         ldOffset_q <= 2'b00;
         ldValid_q  <= 1'b0;
         misalign_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         timeoutCnt_q <= '0;
         busErr_q     <= 1'b0;
`endif
      end else begin
         ldValid_q  <= 1'b0;
         misalign_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         busErr_q   <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (isOp && misaligned) begin
                  misalign_q <= 1'b1;
               end else if (isOp) begin
                  state_q    <= REQ;
                  memReq_q   <= 1'b1;
                  memWe_q    <= i_lsu_wren;
                  memAddr_q  <= {i_addr[ADDR_W-1:2], 2'b00};
                  memBe_q    <= memBe_d;
                  memWdata_q <= memWdata_d;
                  isLoad_q   <= i_lsu_rden;
                  offset_q   <= i_addr[1:0];
`ifdef LSU_TIMEOUT_EN
                  timeoutCnt_q <= '0;
`endif
               end
            end
            REQ: begin
               if (i_mem_ack) begin
                  state_q  <= DONE;
                  memReq_q <= 1'b0;
                  if (isLoad_q) begin
                     ldData_q   <= i_mem_rdata;
                     ldOffset_q <= offset_q;
                     ldValid_q  <= 1'b1;
                  end
               end
`ifdef LSU_TIMEOUT_EN
               // An ack arriving on the terminal count takes the branch above and wins.
               else if (timeoutCnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state_q  <= DONE;
                  memReq_q <= 1'b0;
                  busErr_q <= 1'b1;
               end else begin
                  timeoutCnt_q <= timeoutCnt_q + 1'b1;
               end
`endif
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q  <= IDLE;
               memReq_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_stall     = (state_q == REQ) || (isOp && !misaligned);
   assign o_mem_req   = memReq_q;
   assign o_mem_we    = memWe_q;
   assign o_mem_addr  = memAddr_q;
   assign o_mem_be    = memBe_q;
   assign o_mem_wdata = memWdata_q;
   assign o_ld_data   = ldData_q;
   assign o_ld_offset = ldOffset_q;
   assign o_ld_valid  = ldValid_q;
   assign o_misalign  = misalign_q;
`ifdef LSU_TIMEOUT_EN
   assign o_bus_err   = busErr_q;
`else
   assign o_bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomized bench for lsu_mem_port against a transaction-level reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_lsu_mem_port;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_valid, i_lsu_wren, i_lsu_rden;
   logic [1:0]  i_size;
   logic [31:0] i_addr, i_st_data;
   logic        o_stall, o_mem_req, o_mem_we;
   logic [31:0] o_mem_addr, o_mem_wdata;
   logic [3:0]  o_mem_be;
   logic        i_mem_ack;
   logic [31:0] i_mem_rdata;
   logic [31:0] o_ld_data;
   logic [1:0]  o_ld_offset;
   logic        o_ld_valid, o_misalign, o_bus_err;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] lastLdData = 32'h0;
   logic [1:0]  lastLdOff  = 2'b00;

   lsu_mem_port #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
      .i_clk(clk), .i_reset(reset), .i_valid(i_valid),
      .i_lsu_wren(i_lsu_wren), .i_lsu_rden(i_lsu_rden), .i_size(i_size),
      .i_addr(i_addr), .i_st_data(i_st_data), .o_stall(o_stall),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
      .i_mem_rdata(i_mem_rdata), .o_ld_data(o_ld_data), .o_ld_offset(o_ld_offset),
      .o_ld_valid(o_ld_valid), .o_misalign(o_misalign), .o_bus_err(o_bus_err)
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   // Hard stop so a hung design still reports
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One complete operation: acceptance, ackDelay REQ cycles without ack, then ack and DONE.
   task automatic applyStimulus(input bit wr, input bit rd, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] st,
                                input int ackDelay, input logic [31:0] rdata, input bit pokeDone);
      bit          legal, mis;
      int          off, nbytes;
      logic [3:0]  expBe;
      logic [31:0] expWdata;
      legal  = wr ^ rd;
      off    = int'(addr[1:0]);
      mis    = (size == 2'd3) || (size == 2'd1 && (off % 2) != 0) || (size == 2'd2 && off != 0);
      nbytes = 1 << size;
      expBe  = 4'((((1 << nbytes) - 1) << off) & 15);
      if (size == 2'd0)      expWdata = {24'h0, st[7:0]} * 32'h01010101;
      else if (size == 2'd1) expWdata = {16'h0, st[15:0]} * 32'h00010001;
      else                   expWdata = st;

      @(negedge clk);
      i_valid = 1'b1; i_lsu_wren = wr; i_lsu_rden = rd; i_size = size;
      i_addr = addr; i_st_data = st;
      i_mem_ack = 1'($urandom_range(0, 1));
      i_mem_rdata = $urandom;
      #1;
      checkOutput("stall_accept", 64'(o_stall), 64'(legal && !mis));

      @(negedge clk);
      i_valid = 1'b0; i_lsu_wren = 1'($urandom_range(0, 1)); i_lsu_rden = 1'($urandom_range(0, 1));
      i_addr = $urandom; i_mem_ack = 1'b0;
      #1;
      if (!legal || mis) begin
         checkOutput("misalign_pulse", 64'(o_misalign), 64'(legal && mis));
         checkOutput("req_rejected", 64'(o_mem_req), 64'd0);
         checkOutput("stall_rejected", 64'(o_stall), 64'd0);
         return;
      end

      for (int k = 0; k <= ackDelay; k++) begin
         if (k > 0) begin
            @(negedge clk);
            #1;
         end
         checkOutput("req_high", 64'(o_mem_req), 64'd1);
         checkOutput("stall_req", 64'(o_stall), 64'd1);
         checkOutput("mem_we", 64'(o_mem_we), 64'(wr));
         checkOutput("mem_addr", 64'(o_mem_addr), 64'(addr & 32'hFFFF_FFFC));
         checkOutput("mem_be", 64'(o_mem_be), 64'(expBe));
         if (wr) checkOutput("mem_wdata", 64'(o_mem_wdata), 64'(expWdata));
         i_mem_ack   = (k == ackDelay);
         i_mem_rdata = (k == ackDelay) ? rdata : $urandom;
      end

      @(negedge clk);
      i_mem_ack = 1'b0;
      if (pokeDone) begin
         i_valid = 1'b1; i_lsu_wren = 1'b0; i_lsu_rden = 1'b1; i_size = 2'd2; i_addr = 32'h0000_0100;
      end
      #1;
      if (rd) begin
         lastLdData = rdata;
         lastLdOff  = addr[1:0];
      end
      checkOutput("done_req", 64'(o_mem_req), 64'd0);
      checkOutput("done_stall", 64'(o_stall), 64'd0);
      checkOutput("ld_valid", 64'(o_ld_valid), 64'(rd));
      checkOutput("ld_data", 64'(o_ld_data), 64'(lastLdData));
      checkOutput("ld_offset", 64'(o_ld_offset), 64'(lastLdOff));
      checkOutput("bus_err_quiet", 64'(o_bus_err), 64'd0);
      if (pokeDone) begin
         @(negedge clk);
         i_valid = 1'b0;
         #1;
         checkOutput("done_op_ignored", 64'(o_mem_req), 64'd0);
      end
   endtask

   initial begin
      int cnt;
      reset = 1'b1; i_valid = 1'b0; i_lsu_wren = 1'b0; i_lsu_rden = 1'b0; i_size = 2'd0;
      i_addr = 32'h0; i_st_data = 32'h0; i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_req", 64'(o_mem_req), 64'd0);
      checkOutput("reset_stall", 64'(o_stall), 64'd0);
      checkOutput("reset_ld_data", 64'(o_ld_data), 64'd0);
      checkOutput("reset_be", 64'(o_mem_be), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      applyStimulus(1'b1, 1'b0, 2'd0, 32'h0000_1003, 32'h0000_00A5, 2, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b1, 2'd1, 32'h0000_2002, 32'h0, 0, 32'hBEEF_1234, 1'b0);
      applyStimulus(1'b0, 1'b1, 2'd2, 32'h0000_3001, 32'h0, 0, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 2'd2, 32'h0000_0040, 32'h1122_3344, 0, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b1, 2'd0, 32'h0000_0041, 32'h0, 0, 32'hCAFE_F00D, 1'b0);
      applyStimulus(1'b1, 1'b1, 2'd2, 32'h0000_0080, 32'h0, 0, 32'h0, 1'b0);

      for (int n = 0; n < 200; n++) begin
         logic [31:0] a;
         int mode;
         a = $urandom;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         mode = $urandom_range(0, 7);
         applyStimulus(mode == 0 ? 1'b1 : (mode < 4), mode == 0 ? 1'b1 : (mode >= 4 && mode != 7),
                       2'($urandom_range(0, 3)), a, $urandom, $urandom_range(0, 5), $urandom,
                       $urandom_range(0, 3) == 0);
      end

      // Reset in the middle of a transfer
      @(negedge clk);
      i_valid = 1'b1; i_lsu_wren = 1'b0; i_lsu_rden = 1'b1; i_size = 2'd2; i_addr = 32'h0000_5000;
      @(negedge clk);
      i_valid = 1'b0;
      #1;
      checkOutput("pre_reset_req", 64'(o_mem_req), 64'd1);
      #2 reset = 1'b1;
      #1;
      lastLdData = 32'h0;
      lastLdOff  = 2'b00;
      checkOutput("async_reset_req", 64'(o_mem_req), 64'd0);
      checkOutput("async_reset_stall", 64'(o_stall), 64'd0);
      checkOutput("async_reset_we_be", 64'({o_mem_we, o_mem_be}), 64'd0);
      checkOutput("async_reset_addr", 64'(o_mem_addr), 64'd0);
      checkOutput("async_reset_pulses", 64'({o_ld_valid, o_misalign, o_bus_err}), 64'd0);
      checkOutput("async_reset_ld", 64'({o_ld_data, o_ld_offset}), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1'b0, 1'b1, 2'd2, 32'h0000_4000, 32'h0, 1, 32'h1357_9BDF, 1'b0);

`ifdef LSU_TIMEOUT_EN
      @(negedge clk);
      i_valid = 1'b1; i_lsu_wren = 1'b0; i_lsu_rden = 1'b1; i_size = 2'd2; i_addr = 32'h0000_6000;
      @(negedge clk);
      i_valid = 1'b0;
      #1;
      cnt = 0;
      while (o_mem_req === 1'b1 && cnt < 40) begin
         cnt++;
         @(negedge clk);
         #1;
      end
      checkOutput("timeout_req_cycles", 64'(cnt), 64'd16);
      checkOutput("bus_err_pulse", 64'(o_bus_err), 64'd1);
      checkOutput("timeout_ld_valid", 64'(o_ld_valid), 64'd0);
      checkOutput("timeout_ld_data", 64'(o_ld_data), 64'(lastLdData));
      @(negedge clk);
      #1;
      checkOutput("bus_err_once", 64'(o_bus_err), 64'd0);
      applyStimulus(1'b0, 1'b1, 2'd2, 32'h0000_7000, 32'h0, 15, 32'h2468_ACE0, 1'b0);
`else
      cnt = 0;
      applyStimulus(1'b1, 1'b0, 2'd1, 32'h0000_6002, 32'h0000_BEEF, 20, 32'h0, 1'b0);
      checkOutput("no_bus_err", 64'(o_bus_err + 1'(cnt)), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Memory-stage load/store port; the producing end of the load-data path consumed by writeback.
- Accepts one load or store per request from EX and drives a word-aligned req/ack data-memory bus with byte-lane enables and lane-shifted store data.
- Returns the raw, unaligned-in-lane 32-bit load word plus its byte offset, so writeback can perform sign/zero extension.
- Stalls the pipeline while a bus transaction is in flight.

Parameters:
- ADDR_W, 32, byte address width
- TIMEOUT_CYCLES, 16, cycles to wait for i_mem_ack before abort (used only with the optional feature)

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  EX presents a memory op this cycle
- i_lsu_wren  in  1  op is a store
- i_lsu_rden  in  1  op is a load
- i_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- i_addr  in  ADDR_W  byte address (ALU result)
- i_st_data  in  32  store data, right-justified
- o_stall  out  1  hold EX/MEM; op accepted but not complete
- o_mem_req  out  1  bus request
- o_mem_we  out  1  bus write
- o_mem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0
- o_mem_be  out  4  byte-lane enables
- o_mem_wdata  out  32  lane-shifted store data
- i_mem_ack  in  1  bus completes the current transfer
- i_mem_rdata  in  32  read word, valid with i_mem_ack
- o_ld_data  out  32  raw read word to writeback
- o_ld_offset  out  2  i_addr[1:0] of the completed load
- o_ld_valid  out  1  one-cycle pulse: load data is valid
- o_misalign  out  1  one-cycle pulse: op rejected for misalignment
- o_bus_err  out  1  one-cycle pulse: timeout abort (optional feature only)

Behaviour:
- Clock and reset: single clock i_clk; i_reset is asynchronous, active-high. On reset, every output is 0, the FSM goes to IDLE, and the timeout counter clears.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - An op is accepted when i_valid=1 and exactly one of i_lsu_wren/i_lsu_rden is 1.
  - i_valid with neither or both set: no-op, stay in IDLE.
  - Misaligned op (half with addr[0]=1, word with addr[1:0]!=0, or size=3): pulse o_misalign next cycle, issue no bus transfer, stay in IDLE.
  - Aligned op: latch address/data/size/offset, go to REQ, assert o_stall combinationally in the acceptance cycle.
- REQ:
  - o_mem_req=1; o_mem_addr, o_mem_we, o_mem_be, o_mem_wdata are registered and stable until ack.
  - o_stall=1.
  - On i_mem_ack: for a load, capture i_mem_rdata into o_ld_data; go to DONE.
- DONE (one cycle):
  - o_mem_req=0, o_stall=0.
  - Loads: o_ld_valid=1; o_ld_data and o_ld_offset hold until the next load completes.
  - Return to IDLE. A new op may be accepted in the following cycle, never in DONE itself.
- Byte enables:
  - Byte: be = 1 << off, wdata = {4{st[7:0]}}.
  - Half: be = 4'b0011 << off, wdata = {2{st[15:0]}}.
  - Word: be = 4'b1111, wdata = st.
  - Loads drive the same be values; memory may ignore them.
- Minimum latency: ack in the first REQ cycle gives accept → DONE in 2 clocks.
- An ack in the acceptance cycle, or while in IDLE or DONE, is ignored.
- A transaction stays in REQ indefinitely without ack (without the optional feature).
- Reset mid-transaction drops o_mem_req immediately (asynchronously); the lost transfer is not retried.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 without ack: drop o_mem_req, pulse o_bus_err in the next cycle (DONE), keep o_ld_valid=0, leave o_ld_data unchanged.
  - An ack in the same cycle as the terminal count wins.
- Undefined: no counter; o_bus_err is tied to 0.

Test Plan:
- Store byte, addr=0x1003, st=0x000000A5, ack after 3 cycles → o_mem_addr=0x1000, be=4'b1000, wdata=0xA5A5A5A5; o_stall high for 4 cycles; no o_ld_valid.
- Load half, addr=0x2002, rdata=0xBEEF1234, ack in first REQ cycle → o_ld_valid pulse 2 cycles after accept, o_ld_data=0xBEEF1234, o_ld_offset=2, be=4'b1100.
- Load word, addr=0x3001 → o_misalign pulse, o_mem_req never asserted, o_stall=0.
- Back-to-back: store then load, both with immediate ack → second accepted no earlier than the cycle after the first DONE; bus transfers never overlap.
- i_reset asserted mid-REQ → all outputs 0 asynchronously; after release, a new word load at 0x4000 completes normally.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack → o_mem_req drops after 16 REQ cycles, o_bus_err pulses once, o_ld_data unchanged.
